// File: rtl/uart_pkg.sv
// Shared ASCII constants, FSM encoding and frame-length helpers for the decimal line sender.
// UART_DEC_CRLF_EN appends CR/LF to every frame.
package uart_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

`ifdef UART_DEC_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD,
        ST_WAIT,
        ST_FIN
    } state_e;

    // tag + colon + digits, plus CR/LF when enabled
    function automatic int frame_len(input int digits, input bit crlf);
        return digits + 2 + (crlf ? 2 : 0);
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: DATA_W shift-add-3 cycles after start, then a one-cycle done pulse.
// ovf flags a latched value that does not fit in DIGITS decimal digits.
module bin2bcd_seq
    import uart_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic                  done
);

    localparam int          BCD_W   = 4 * DIGITS;
    localparam int          CNT_W   = $clog2(DATA_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;

        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
            // Saturation decision uses the full binary value, not truncated BCD digits
            ovf_d = (64'(bin) > MAX_VAL);
        end else if (run_q) begin
            bcd_d = {adj[BCD_W-2:0], sh_q[DATA_W-1]};
            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

// File: rtl/uart_dec_sender.sv
// Converts a latched binary value to a "<tag>:<digits>" text line and feeds it byte by byte to a UART TX.
// Next byte is started one cycle after tx_done; UART_DEC_CRLF_EN appends CR/LF to the frame.
module uart_dec_sender
    import uart_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] value,
    input  logic [7:0]        tag,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int N     = frame_len(DIGITS, CRLF_EN);
    localparam int IDX_W = $clog2(N + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, ld_idx;
    logic [7:0]           tag_q, tag_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [7:0]           ld_char;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cv_start, cv_done, cv_ovf;
    logic [4*DIGITS-1:0]  cv_bcd;

    // Byte pacing comes only from tx_done; the busy flag is deliberately not consulted
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cv_start),
        .bin   (value),
        .bcd   (cv_bcd),
        .ovf   (cv_ovf),
        .done  (cv_done)
    );

    // Index of the byte that would be loaded this cycle
    assign ld_idx = (state_q == ST_WAIT) ? idx_q + IDX_W'(1) : idx_q;

    always_comb begin
        ld_char = ASC_0;
        if (ld_idx == '0) ld_char = tag_q;
        else if (ld_idx == IDX_W'(1)) ld_char = ASC_COLON;
        for (int d = 0; d < DIGITS; d++) begin
            if (ld_idx == IDX_W'(d + 2))
                ld_char = ASC_0 + {4'd0, (cv_ovf ? 4'd9 : cv_bcd[4*(DIGITS-1-d) +: 4])};
        end
`ifdef UART_DEC_CRLF_EN
        if (ld_idx == IDX_W'(DIGITS + 2)) ld_char = ASC_CR;
        if (ld_idx == IDX_W'(DIGITS + 3)) ld_char = ASC_LF;
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        cv_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    tag_d    = tag;
                    idx_d    = '0;
                    cv_start = 1'b1;
                    state_d  = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cv_done) begin
                    tx_data_d  = ld_char;
                    tx_start_d = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        tx_data_d  = ld_char;
                        tx_start_d = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tag_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_dec_sender.sv
// Scoreboard bench for uart_dec_sender: expected frame bytes are queued at send and matched on each tx_start.
module tb_uart_dec_sender;

    localparam int DATA_W = 16;
    localparam int DIGITS = 5;
    localparam int DIG4   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [15:0] value = '0;
    logic [7:0]  tag = '0;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    logic        send4 = 1'b0;
    logic [15:0] value4 = '0;
    logic [7:0]  tag4 = '0;
    logic        tx_busy4 = 1'b0;
    logic        tx_done4 = 1'b0;
    logic        tx_start4;
    logic [7:0]  tx_data4;
    logic        busy4;
    logic        done4;

    uart_dec_sender #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_dut (
        .clk(clk), .rst_n(rst_n), .send(send), .value(value), .tag(tag),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .done(done)
    );

    uart_dec_sender #(.DATA_W(DATA_W), .DIGITS(DIG4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .send(send4), .value(value4), .tag(tag4),
        .tx_busy(tx_busy4), .tx_done(tx_done4), .tx_start(tx_start4),
        .tx_data(tx_data4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errs = 0;
    int         checks = 0;
    logic [7:0] sb[$];
    logic [7:0] got4[$];
    int         exp_start = -1;
    int         last_done = -1;
    int         nbytes = 0;
    int         tx_cnt = 0;
    bit         prev_start = 1'b0;
    bit         stray_req = 1'b0;
    bit         pend4 = 1'b0;

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, obs, exp, cyc);
        end
    endtask

    function automatic int flen(input int d);
`ifdef UART_DEC_CRLF_EN
        return d + 4;
`else
        return d + 2;
`endif
    endfunction

    function automatic logic [7:0] exp_char(input logic [7:0] t, input int v, input int d, input int i);
        int lim = 1;
        int pw = 1;
        int dig;
        for (int k = 0; k < d; k++) lim *= 10;
        if (i == 0) return t;
        if (i == 1) return 8'h3A;
        if (i < d + 2) begin
            for (int k = 0; k < d - 1 - (i - 2); k++) pw *= 10;
            dig = (v > lim - 1) ? 9 : (v / pw) % 10;
            return 8'h30 + 8'(dig);
        end
        return (i == d + 2) ? 8'h0D : 8'h0A;
    endfunction

    // Transmitter model for the main DUT: each byte takes 3 cycles, then a tx_done pulse
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            tx_cnt     = 0;
            tx_busy    = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                check("b2b_start", prev_start, 0);
                check("start_cyc", cyc, exp_start);
                exp_start = -1;
                check("byte_expected", sb.size() != 0, 1);
                if (sb.size() != 0) check("byte", tx_data, sb.pop_front());
                nbytes++;
                tx_busy = 1'b1;
                tx_cnt  = 3;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done   = 1'b1;
                    tx_busy   = 1'b0;
                    last_done = cyc;
                    exp_start = cyc + 1;
                end
            end else if (stray_req) begin
                tx_done   = 1'b1;
                stray_req = 1'b0;
            end
            prev_start = tx_start;
        end
    end

    // Fast transmitter for the 4-digit DUT: done one cycle after start
    always @(negedge clk) begin
        tx_done4 = pend4;
        pend4    = tx_start4 && rst_n;
        tx_busy4 = pend4;
        if (tx_start4) got4.push_back(tx_data4);
    end

    task automatic send_frame(input logic [7:0] t, input int v);
        @(negedge clk);
        check("idle_before_send", busy, 0);
        for (int i = 0; i < flen(DIGITS); i++) sb.push_back(exp_char(t, v, DIGITS, i));
        tag       = t;
        value     = v[15:0];
        send      = 1'b1;
        nbytes    = 0;
        exp_start = cyc + DATA_W + 2;
        @(negedge clk);
        send  = 1'b0;
        value = 16'hBEEF;
        tag   = 8'h3F;
        check("busy_after_send", busy, 1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_seen"}, done, 1);
        check({nm, "_done_cyc"}, cyc, last_done + 1);
        check({nm, "_busy_at_done"}, busy, 1);
        check({nm, "_bytes_left"}, sb.size(), 0);
        @(negedge clk);
        check({nm, "_busy_clear"}, busy, 0);
        check({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h54, 1234);
        wait_done("f1234");
        check("f1234_nbytes", nbytes, flen(DIGITS));

        send_frame(8'h41, 0);
        wait_done("fzero");

        // Stray tx_done while converting must be ignored
        send_frame(8'h78, 42);
        stray_req = 1'b1;
        wait_done("fstray");

        // send during the 3rd byte's WAIT is ignored
        send_frame(8'h5A, 65535);
        n = 0;
        while (nbytes < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        send  = 1'b1;
        value = 16'd5;
        tag   = 8'h51;
        @(negedge clk);
        send = 1'b0;
        wait_done("fmax");
        repeat (40) @(negedge clk);
        check("ignored_send_busy", busy, 0);
        check("ignored_send_nbytes", nbytes, flen(DIGITS));

        // Reset during the 5th byte
        send_frame(8'h72, 777);
        n = 0;
        while (nbytes < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        sb.delete();
        exp_start = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h52, 31337);
        wait_done("fresh");
        check("fresh_nbytes", nbytes, flen(DIGITS));

        // Saturation with 4 digits
        @(negedge clk);
        tag4   = 8'h53;
        value4 = 16'd12000;
        send4  = 1'b1;
        @(negedge clk);
        send4  = 1'b0;
        value4 = 16'd1;
        n = 0;
        while (!done4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("d4_done", done4, 1);
        check("d4_len", got4.size(), flen(DIG4));
        for (int i = 0; i < got4.size() && i < flen(DIG4); i++)
            check("d4_byte", got4[i], exp_char(8'h53, 12000, DIG4, i));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
